// File: rtl/bram_pkg.sv
// bram_pkg: shared constants and types for the dual-port round-robin BRAM arbiter.
package bram_pkg;
  localparam int BRAM_ADDR_W = 11;
  localparam int BRAM_DATA_W = 16;
  localparam int BRAM_DEPTH = 2048;
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;
  typedef struct packed {
    logic vld;
    logic id;
  } rd_tag_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-input round-robin arbiter; the pointer names the port favoured on contention.
import bram_pkg::*;

module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  logic ptr_q, ptr_d;
  always_comb begin
    gnt_o[0] = req_i[0] & (~req_i[1] | (ptr_q == PORT_A));
    gnt_o[1] = req_i[1] & (~req_i[0] | (ptr_q == PORT_B));
    ptr_d = gnt_o[0] ? PORT_B : gnt_o[1] ? PORT_A : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= rst ? PORT_A : ptr_d;
endmodule

// File: rtl/bram_rr_arbiter.sv
// bram_rr_arbiter: two requesters sharing one single-port BRAM with round-robin grants.
// Define BRAM_ARB_STATS_EN to add saturating per-port grant counters.
import bram_pkg::*;

module bram_rr_arbiter #(
  parameter int ADDR_W = BRAM_ADDR_W,
  parameter int DATA_W = BRAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
`ifdef BRAM_ARB_STATS_EN
  output logic [15:0]       a_grant_cnt,
  output logic [15:0]       b_grant_cnt,
`endif
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);
  logic [1:0] gnt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q, a_rdata_q, b_rdata_q;
  rd_tag_t tag_q, tag_d;
  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req_i ({b_valid, a_valid}),
    .gnt_o (gnt)
  );
  // Idle cycles keep the RAM address/data bus steady and never write.
  always_comb begin
    a_ready = gnt[0];
    b_ready = gnt[1];
    mem_we = gnt[0] ? a_we : gnt[1] ? b_we : 1'b0;
    mem_addr = gnt[0] ? a_addr : gnt[1] ? b_addr : addr_q;
    mem_din = gnt[0] ? a_wdata : gnt[1] ? b_wdata : din_q;
    tag_d.vld = (gnt[0] & ~a_we) | (gnt[1] & ~b_we);
    tag_d.id = gnt[1] ? PORT_B : PORT_A;
    a_rvalid = tag_q.vld & (tag_q.id == PORT_A) & ~rst;
    b_rvalid = tag_q.vld & (tag_q.id == PORT_B) & ~rst;
    a_rdata = a_rvalid ? mem_dout : a_rdata_q;
    b_rdata = b_rvalid ? mem_dout : b_rdata_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_q <= '0;
      addr_q <= '0;
      din_q <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      tag_q <= tag_d;
      addr_q <= mem_addr;
      din_q <= mem_din;
      a_rdata_q <= a_rdata;
      b_rdata_q <= b_rdata;
    end
  end
`ifdef BRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      a_grant_cnt <= '0;
      b_grant_cnt <= '0;
    end else begin
      a_grant_cnt <= (gnt[0] && a_grant_cnt != 16'hFFFF) ? a_grant_cnt + 16'd1 : a_grant_cnt;
      b_grant_cnt <= (gnt[1] && b_grant_cnt != 16'hFFFF) ? b_grant_cnt + 16'd1 : b_grant_cnt;
    end
  end
`endif
endmodule

// File: tb/tb_bram_rr_arbiter.sv
// tb_bram_rr_arbiter: directed bench with a behavioural registered-output RAM model.
module tb_bram_rr_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic a_valid, a_ready, a_we, a_rvalid;
  logic b_valid, b_ready, b_we, b_rvalid;
  logic [10:0] a_addr, b_addr, mem_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_din, mem_dout;
  logic mem_we;
  logic [15:0] ram [2048];
  int checks = 0;
  int errors = 0;
`ifdef BRAM_ARB_STATS_EN
  logic [15:0] a_grant_cnt, b_grant_cnt;
`endif
  always #5 clk = ~clk;
  bram_rr_arbiter dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
`ifdef BRAM_ARB_STATS_EN
    .a_grant_cnt(a_grant_cnt), .b_grant_cnt(b_grant_cnt),
`endif
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    mem_dout <= ram[mem_addr];
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic drv_a(input logic v, input logic we, input logic [10:0] ad, input logic [15:0] d);
    a_valid = v; a_we = we; a_addr = ad; a_wdata = d;
  endtask
  task automatic drv_b(input logic v, input logic we, input logic [10:0] ad, input logic [15:0] d);
    b_valid = v; b_we = we; b_addr = ad; b_wdata = d;
  endtask
  initial begin
    rst = 1'b1;
    drv_a(0, 0, 0, 0);
    drv_b(0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_b_rvalid", b_rvalid, 0);
    chk("rst_a_rdata", a_rdata, 0);
    chk("rst_b_rdata", b_rdata, 0);
    rst = 1'b0;
    drv_a(1, 1, 11'h005, 16'hBEEF);
    #1;
    chk("wr_a_ready", a_ready, 1);
    chk("wr_b_ready", b_ready, 0);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 11'h005);
    chk("wr_mem_din", mem_din, 16'hBEEF);
    @(negedge clk);
    drv_a(1, 0, 11'h005, 0);
    #1;
    chk("rd_a_ready", a_ready, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("rd_a_rvalid_early", a_rvalid, 0);
    @(negedge clk);
    drv_a(0, 0, 0, 0);
    #1;
    chk("rd_a_rvalid", a_rvalid, 1);
    chk("rd_a_rdata", a_rdata, 16'hBEEF);
    chk("rd_b_rvalid", b_rvalid, 0);
    @(negedge clk);
    #1;
    chk("rd_a_rvalid_drop", a_rvalid, 0);
    chk("rd_a_rdata_hold", a_rdata, 16'hBEEF);
    // Preload contention addresses: A write then B write leaves the pointer on A.
    @(negedge clk);
    drv_a(1, 1, 11'h010, 16'h1111);
    @(negedge clk);
    drv_a(0, 0, 0, 0);
    drv_b(1, 1, 11'h020, 16'h2222);
    #1;
    chk("pre_b_ready", b_ready, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drv_a(1, 0, 11'h010, 0);
      drv_b(1, 0, 11'h020, 0);
      #1;
      chk($sformatf("alt%0d_a_ready", i), a_ready, (i % 2 == 0));
      chk($sformatf("alt%0d_b_ready", i), b_ready, (i % 2 == 1));
      chk($sformatf("alt%0d_a_rvalid", i), a_rvalid, (i > 0) && (i % 2 == 1));
      chk($sformatf("alt%0d_b_rvalid", i), b_rvalid, (i > 0) && (i % 2 == 0));
      if (i > 0) chk($sformatf("alt%0d_rdata", i), (i % 2 == 1) ? a_rdata : b_rdata,
                     (i % 2 == 1) ? 16'h1111 : 16'h2222);
    end
    @(negedge clk);
    drv_a(0, 0, 0, 0);
    drv_b(0, 0, 0, 0);
    #1;
    chk("alt_last_b_rvalid", b_rvalid, 1);
    chk("alt_last_b_rdata", b_rdata, 16'h2222);
    chk("alt_last_a_rvalid", a_rvalid, 0);
    @(negedge clk);
    drv_b(1, 1, 11'h7FF, 16'h1234);
    #1;
    chk("top_b_ready", b_ready, 1);
    chk("top_mem_we", mem_we, 1);
    chk("top_mem_addr", mem_addr, 11'h7FF);
    @(negedge clk);
    drv_b(0, 0, 0, 0);
    drv_a(1, 0, 11'h7FF, 0);
    #1;
    chk("top_a_ready", a_ready, 1);
    @(negedge clk);
    drv_a(0, 0, 0, 0);
    #1;
    chk("top_a_rvalid", a_rvalid, 1);
    chk("top_a_rdata", a_rdata, 16'h1234);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("idle%0d_mem_we", i), mem_we, 0);
      chk($sformatf("idle%0d_ready", i), {a_ready, b_ready}, 0);
      chk($sformatf("idle%0d_rvalid", i), {a_rvalid, b_rvalid}, 0);
      chk($sformatf("idle%0d_mem_addr", i), mem_addr, 11'h7FF);
    end
    // Pointer favoured B before idling (last grant was A).
    @(negedge clk);
    drv_a(1, 0, 11'h010, 0);
    drv_b(1, 0, 11'h020, 0);
    #1;
    chk("post_idle_b_ready", b_ready, 1);
    chk("post_idle_a_ready", a_ready, 0);
    @(negedge clk);
    drv_b(0, 0, 0, 0);
    #1;
    chk("post_idle_a_ready2", a_ready, 1);
    chk("post_idle_b_rvalid", b_rvalid, 1);
    chk("post_idle_b_rdata", b_rdata, 16'h2222);
    @(negedge clk);
    drv_a(0, 0, 0, 0);
    #1;
    chk("post_idle_a_rvalid", a_rvalid, 1);
    chk("post_idle_a_rdata", a_rdata, 16'h1111);
    @(negedge clk);
    drv_a(1, 0, 11'h005, 0);
    #1;
    chk("mid_a_ready", a_ready, 1);
    @(negedge clk);
    drv_a(0, 0, 0, 0);
    rst = 1'b1;
    #1;
    chk("mid_rst_a_rvalid", a_rvalid, 0);
    @(negedge clk);
    #1;
    chk("mid_post_a_rvalid", a_rvalid, 0);
    chk("mid_post_b_rvalid", b_rvalid, 0);
    chk("mid_post_a_rdata", a_rdata, 0);
    chk("mid_post_b_rdata", b_rdata, 0);
    rst = 1'b0;
    @(negedge clk);
    drv_a(1, 0, 11'h005, 0);
    drv_b(1, 0, 11'h7FF, 0);
    #1;
    chk("rst_ptr_a_ready", a_ready, 1);
    chk("rst_ptr_b_ready", b_ready, 0);
    @(negedge clk);
    drv_a(0, 0, 0, 0);
    #1;
    chk("keep_b_ready", b_ready, 1);
    chk("keep_a_rvalid", a_rvalid, 1);
    chk("keep_a_rdata", a_rdata, 16'hBEEF);
    @(negedge clk);
    drv_b(0, 0, 0, 0);
    #1;
    chk("keep_b_rvalid", b_rvalid, 1);
    chk("keep_b_rdata", b_rdata, 16'h1234);
`ifdef BRAM_ARB_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drv_a(1, 1, 11'h100, 16'h5A5A);
    repeat (3) @(negedge clk);
    #1;
    chk("cnt_a_3", a_grant_cnt, 3);
    repeat (69997) @(negedge clk);
    #1;
    chk("cnt_a_sat", a_grant_cnt, 16'hFFFF);
    chk("cnt_b_zero", b_grant_cnt, 0);
    drv_a(0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("cnt_a_rst", a_grant_cnt, 0);
    chk("cnt_b_rst", b_grant_cnt, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
